control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 toCU  input  3  opcode field, bits [7:5] of the current memory output byte.
REQ-004 zFlag, nFlag  input  1 each  Z and N flag register outputs from the datapath.
REQ-005 pcEn, selPC  output  1 each  PC load enable; selPC 0 selects PC+1, 1 selects the 13-bit instruction address.
REQ-006 selAddress  output  1  memory address select; 0 selects PC, 1 selects the instruction address.
REQ-007 mr, mw  output  1 each  memory read and memory write strobes.
REQ-008 LSEn, RSEn, DIEn, wordRegEn, dataRegEn, resultRegEn  output  1 each  datapath register load enables.
REQ-009 selData  output  2  accumulator write source: 00 word reg, 01 result reg, 10 data reg.
REQ-010 enb  output  1  accumulator write enable.
REQ-011 CEn, ZEn, NEn  output  1 each  flag register load enables.
REQ-012 aluOp  output  2  ALU operation: 00 ADD, 01 AND, 10 SUB.
REQ-013 instrDone, halted  output  1 each  one-cycle pulse in each instruction's last cycle; halted is level while in HALT.

Function
REQ-014 The block SHALL be a Moore FSM; every output is decoded from the state register and the latched opcode only. All outputs not listed for a state are 0.
REQ-015 The block SHALL latch toCU into an internal 3-bit opReg at the end of FETCH1.
REQ-016 FETCH1: mr=1, LSEn=1, pcEn=1, selPC=0, selAddress=0. Next state is FETCH2.
REQ-017 FETCH2: mr=1, RSEn=1, pcEn=1, selPC=0, selAddress=0. Next state is DECODE.
REQ-018 DECODE: DIEn=1. Next state is set by opReg per REQ-019 to REQ-025.
REQ-019 Opcode 000 LDA: MEMRD (selAddress=1, mr=1, wordRegEn=1), then WB (selData=00, enb=1, instrDone=1); 5 cycles total.
REQ-020 Opcode 001 STA: LDDATA (dataRegEn=1), then MEMWR (selAddress=1, mw=1, instrDone=1); 5 cycles total.
REQ-021 Opcodes 010 ADD, 011 AND, 101 SUB: MEMRD, then EXEC (resultRegEn=1, CEn=ZEn=NEn=1, aluOp per opcode), then WB (selData=01, enb=1, instrDone=1); 6 cycles total.
REQ-022 aluOp SHALL be held at the opcode's value in MEMRD, EXEC and WB of an ALU instruction, and at 00 otherwise.
REQ-023 Opcode 100 JMP: JUMP (pcEn=1, selPC=1, instrDone=1); 4 cycles total.
REQ-024 Opcode 110: handled per REQ-030/REQ-031.
REQ-025 Opcode 111 HLT: go to HALT (halted=1, instrDone=0, all enables 0). Stay in HALT until rst.
REQ-026 After any state that asserts instrDone, the next state SHALL be FETCH1.
REQ-027 mr and mw SHALL never be asserted in the same cycle; pcEn SHALL never be asserted in any state other than FETCH1, FETCH2 and JUMP.

Reset
REQ-028 When rst=1 at a clock edge, the state SHALL become FETCH1 and opReg SHALL become 000, regardless of the current state, including HALT and mid-instruction.
REQ-029 In the cycle after reset, outputs SHALL be the FETCH1 values: mr=1, LSEn=1, pcEn=1; all other outputs 0, including halted and instrDone.

Configuration
REQ-030 With macro CU_COND_JUMP_EN defined, opcode 110 is JZN. In DECODE, if zFlag|nFlag=1, next state is JUMP. Otherwise next state is SKIP (instrDone=1, all enables 0). Flags are sampled in DECODE.
REQ-031 With CU_COND_JUMP_EN undefined, opcode 110 is a NOP: DECODE goes to SKIP, and the flag inputs are ignored.

Verification
REQ-032 Assert rst for 1 cycle, then drive toCU=000 -> state sequence FETCH1, FETCH2, DECODE, MEMRD, WB; WB shows selData=00, enb=1, instrDone=1; the next cycle is FETCH1.
REQ-033 toCU=010 -> EXEC shows resultRegEn=CEn=ZEn=NEn=1 with aluOp=00; WB shows selData=01, enb=1; 6 cycles counted from FETCH1 to FETCH1.
REQ-034 toCU=001 -> LDDATA has dataRegEn=1, then MEMWR has mw=1, mr=0, selAddress=1; no enb in any cycle.
REQ-035 toCU=110, zFlag=1, with CU_COND_JUMP_EN defined -> JUMP has pcEn=1, selPC=1. Repeat with zFlag=nFlag=0 -> SKIP, no pcEn. Repeat with the macro undefined -> SKIP regardless of flags.
REQ-036 toCU=111 -> halted=1 held for 20 cycles with all enables 0. Assert rst -> FETCH1 the next cycle. Assert rst during EXEC of an ADD -> FETCH1 the next cycle, with no WB and no enb.

Source files
------------

// File: rtl/control_unit_if.sv
// Control-unit boundary bundle: opcode and flags in, datapath strobes out.
// master is the control unit; slave is the datapath / memory side.
interface control_unit_if;
  logic [2:0] toCU;
  logic       zFlag;
  logic       nFlag;
  logic       pcEn;
  logic       selPC;
  logic       selAddress;
  logic       mr;
  logic       mw;
  logic       LSEn;
  logic       RSEn;
  logic       DIEn;
  logic       wordRegEn;
  logic       dataRegEn;
  logic       resultRegEn;
  logic [1:0] selData;
  logic       enb;
  logic       CEn;
  logic       ZEn;
  logic       NEn;
  logic [1:0] aluOp;
  logic       instrDone;
  logic       halted;

  modport master (
    input  toCU, zFlag, nFlag,
    output pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn,
           dataRegEn, resultRegEn, selData, enb, CEn, ZEn, NEn, aluOp,
           instrDone, halted
  );

  modport slave (
    output toCU, zFlag, nFlag,
    input  pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn,
           dataRegEn, resultRegEn, selData, enb, CEn, ZEn, NEn, aluOp,
           instrDone, halted
  );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the accumulator CPU: fetch/decode/execute with registered outputs.
// Define CU_COND_JUMP_EN to make opcode 110 a flag-conditional jump (JZN); otherwise it is a NOP.
//
// state   | meaning
// FETCH1  | read first instruction byte, latch opcode, PC+1
// FETCH2  | read second instruction byte, PC+1
// DECODE  | load instruction address register, branch on opcode
// MEMRD   | read operand at instruction address
// EXEC    | ALU op into result reg, update C/Z/N
// WB      | write accumulator (word reg or result reg)
// LDDATA  | load data reg from accumulator
// MEMWR   | write data reg to instruction address
// JUMP    | load PC with instruction address
// SKIP    | no-op completion
// HALT    | stopped until reset
module control_unit (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_DECODE, S_MEMRD, S_EXEC, S_WB,
    S_LDDATA, S_MEMWR, S_JUMP, S_SKIP, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       sel_pc;
    logic       sel_address;
    logic       mr;
    logic       mw;
    logic       ls_en;
    logic       rs_en;
    logic       di_en;
    logic       word_en;
    logic       data_en;
    logic       result_en;
    logic [1:0] sel_data;
    logic       enb;
    logic       c_en;
    logic       z_en;
    logic       n_en;
    logic [1:0] alu_op;
    logic       done;
    logic       halted;
  } ctrl_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_JZN = 3'b110;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       take_jump;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_SUB);
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_AND:  return 2'b01;
      OP_SUB:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Output word for a state; registered from the next-state so outputs track state_q.
  function automatic ctrl_t decode(input state_t s, input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH1: begin c.mr = 1'b1; c.ls_en = 1'b1; c.pc_en = 1'b1; end
      S_FETCH2: begin c.mr = 1'b1; c.rs_en = 1'b1; c.pc_en = 1'b1; end
      S_DECODE: c.di_en = 1'b1;
      S_MEMRD: begin
        c.sel_address = 1'b1;
        c.mr          = 1'b1;
        c.word_en     = 1'b1;
        if (is_alu(op)) c.alu_op = alu_code(op);
      end
      S_EXEC: begin
        c.result_en = 1'b1;
        c.c_en      = 1'b1;
        c.z_en      = 1'b1;
        c.n_en      = 1'b1;
        c.alu_op    = alu_code(op);
      end
      S_WB: begin
        c.enb  = 1'b1;
        c.done = 1'b1;
        if (is_alu(op)) begin
          c.sel_data = 2'b01;
          c.alu_op   = alu_code(op);
        end
      end
      S_LDDATA: c.data_en = 1'b1;
      S_MEMWR:  begin c.sel_address = 1'b1; c.mw = 1'b1; c.done = 1'b1; end
      S_JUMP:   begin c.pc_en = 1'b1; c.sel_pc = 1'b1; c.done = 1'b1; end
      S_SKIP:   c.done = 1'b1;
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

`ifdef CU_COND_JUMP_EN
  assign take_jump = cu.zFlag | cu.nFlag;
`else
  logic unused_flags;
  assign unused_flags = cu.zFlag ^ cu.nFlag;
  assign take_jump    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH1: begin op_d = cu.toCU; state_d = S_FETCH2; end
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_AND, OP_SUB: state_d = S_MEMRD;
          OP_STA:  state_d = S_LDDATA;
          OP_JMP:  state_d = S_JUMP;
          OP_JZN:  state_d = take_jump ? S_JUMP : S_SKIP;
          default: state_d = S_HALT;
        endcase
      end
      S_MEMRD:  state_d = is_alu(op_q) ? S_EXEC : S_WB;
      S_EXEC:   state_d = S_WB;
      S_LDDATA: state_d = S_MEMWR;
      S_WB, S_MEMWR, S_JUMP, S_SKIP: state_d = S_FETCH1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH1;
    endcase
    ctrl_d = decode(state_d, op_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH1;
      op_q    <= 3'b000;
      ctrl_q  <= decode(S_FETCH1, 3'b000);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign cu.pcEn        = ctrl_q.pc_en;
  assign cu.selPC       = ctrl_q.sel_pc;
  assign cu.selAddress  = ctrl_q.sel_address;
  assign cu.mr          = ctrl_q.mr;
  assign cu.mw          = ctrl_q.mw;
  assign cu.LSEn        = ctrl_q.ls_en;
  assign cu.RSEn        = ctrl_q.rs_en;
  assign cu.DIEn        = ctrl_q.di_en;
  assign cu.wordRegEn   = ctrl_q.word_en;
  assign cu.dataRegEn   = ctrl_q.data_en;
  assign cu.resultRegEn = ctrl_q.result_en;
  assign cu.selData     = ctrl_q.sel_data;
  assign cu.enb         = ctrl_q.enb;
  assign cu.CEn         = ctrl_q.c_en;
  assign cu.ZEn         = ctrl_q.z_en;
  assign cu.NEn         = ctrl_q.n_en;
  assign cu.aluOp       = ctrl_q.alu_op;
  assign cu.instrDone   = ctrl_q.done;
  assign cu.halted      = ctrl_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the expected
// per-cycle control words; a monitor compares them against the DUT every cycle.
module tb_control_unit;

  typedef struct packed {
    logic       pc_en;
    logic       sel_pc;
    logic       sel_address;
    logic       mr;
    logic       mw;
    logic       ls_en;
    logic       rs_en;
    logic       di_en;
    logic       word_en;
    logic       data_en;
    logic       result_en;
    logic [1:0] sel_data;
    logic       enb;
    logic       c_en;
    logic       z_en;
    logic       n_en;
    logic [1:0] alu_op;
    logic       done;
    logic       halted;
  } cw_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_unit_if cu_if ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu_if)
  );

  cw_t   exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_active = 1'b0;

  function automatic cw_t actual();
    cw_t a;
    a.pc_en = cu_if.pcEn;          a.sel_pc = cu_if.selPC;
    a.sel_address = cu_if.selAddress;
    a.mr = cu_if.mr;               a.mw = cu_if.mw;
    a.ls_en = cu_if.LSEn;          a.rs_en = cu_if.RSEn;
    a.di_en = cu_if.DIEn;          a.word_en = cu_if.wordRegEn;
    a.data_en = cu_if.dataRegEn;   a.result_en = cu_if.resultRegEn;
    a.sel_data = cu_if.selData;    a.enb = cu_if.enb;
    a.c_en = cu_if.CEn;            a.z_en = cu_if.ZEn;
    a.n_en = cu_if.NEn;            a.alu_op = cu_if.aluOp;
    a.done = cu_if.instrDone;      a.halted = cu_if.halted;
    return a;
  endfunction

  // Control word for a named micro-step of an instruction.
  function automatic cw_t step(input string ph, input logic [1:0] alu, input logic [1:0] src);
    cw_t w;
    w = '0;
    if (ph == "FETCH1")      begin w.mr = 1; w.ls_en = 1; w.pc_en = 1; end
    else if (ph == "FETCH2") begin w.mr = 1; w.rs_en = 1; w.pc_en = 1; end
    else if (ph == "DECODE") w.di_en = 1;
    else if (ph == "MEMRD")  begin w.sel_address = 1; w.mr = 1; w.word_en = 1; w.alu_op = alu; end
    else if (ph == "EXEC")   begin w.result_en = 1; w.c_en = 1; w.z_en = 1; w.n_en = 1; w.alu_op = alu; end
    else if (ph == "WB")     begin w.sel_data = src; w.enb = 1; w.done = 1; w.alu_op = alu; end
    else if (ph == "LDDATA") w.data_en = 1;
    else if (ph == "MEMWR")  begin w.sel_address = 1; w.mw = 1; w.done = 1; end
    else if (ph == "JUMP")   begin w.pc_en = 1; w.sel_pc = 1; w.done = 1; end
    else if (ph == "SKIP")   w.done = 1;
    else if (ph == "HALT")   w.halted = 1;
    return w;
  endfunction

  // Issue one instruction starting at a negedge that precedes its FETCH1 cycle.
  // cut>0 truncates it to that many cycles (the next instruction must then reset).
  task automatic issue(input logic [2:0] op, input logic z, input logic n,
                       input logic with_rst, input int cut, input int halt_n,
                       output logic needs_rst);
    string      phs[$];
    logic [1:0] alu;
    logic [1:0] src;
    logic       jz;
    int         len;
    alu = 2'd0;
    src = 2'd0;
`ifdef CU_COND_JUMP_EN
    jz = z | n;
`else
    jz = 1'b0;
`endif
    phs = '{"FETCH1", "FETCH2", "DECODE"};
    needs_rst = 1'b0;
    case (op)
      3'd0: begin phs.push_back("MEMRD"); phs.push_back("WB"); end
      3'd1: begin phs.push_back("LDDATA"); phs.push_back("MEMWR"); end
      3'd2, 3'd3, 3'd5: begin
        alu = (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2;
        src = 2'd1;
        phs.push_back("MEMRD"); phs.push_back("EXEC"); phs.push_back("WB");
      end
      3'd4: phs.push_back("JUMP");
      3'd6: phs.push_back(jz ? "JUMP" : "SKIP");
      default: begin
        for (int i = 0; i < halt_n; i++) phs.push_back("HALT");
        needs_rst = 1'b1;
      end
    endcase
    len = phs.size();
    if (cut > 0 && cut < len) begin
      len = cut;
      needs_rst = 1'b1;
    end
    rst = with_rst;
    cu_if.toCU = op;
    cu_if.zFlag = z;
    cu_if.nFlag = n;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(step(phs[i], alu, src));
      name_q.push_back($sformatf("op%0d_%s", op, phs[i]));
    end
    mon_active = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_active) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: DUT cycle with no expected word at %0t", $time);
      end else begin
        cw_t   e;
        cw_t   a;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = actual();
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
      end
    end
  end

  initial begin
    logic nr;
    logic [2:0] op;
    int cut;
    cu_if.toCU = 3'd0;
    cu_if.zFlag = 1'b0;
    cu_if.nFlag = 1'b0;
    repeat (2) @(negedge clk);

    issue(3'd0, 0, 0, 1, 0, 0, nr);   // LDA after reset
    issue(3'd2, 0, 0, 0, 0, 0, nr);   // ADD
    issue(3'd1, 0, 0, 0, 0, 0, nr);   // STA
    issue(3'd6, 1, 0, 0, 0, 0, nr);   // JZN z=1
    issue(3'd6, 0, 0, 0, 0, 0, nr);   // JZN no flags
    issue(3'd6, 0, 1, 0, 0, 0, nr);   // JZN n=1
    issue(3'd4, 0, 0, 0, 0, 0, nr);   // JMP
    issue(3'd5, 1, 1, 0, 0, 0, nr);   // SUB
    issue(3'd3, 0, 0, 0, 0, 0, nr);   // AND
    issue(3'd2, 0, 0, 0, 5, 0, nr);   // ADD reset during EXEC
    issue(3'd7, 0, 0, 1, 0, 20, nr);  // HLT held 20 cycles
    issue(3'd0, 0, 0, 1, 0, 0, nr);   // reset out of HALT

    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0;
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nr, cut,
            int'($urandom_range(1, 8)), nr);
    end
    mon_active = 1'b0;
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
